// File: rtl/fir_decim_fifo_if.sv
// Sample stream bus for the decimator/FIFO block: producer side, ratio control,
// and the consumer-facing FIFO head with its status.
interface fir_decim_fifo_if #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    logic [DATA_W-1:0]          in_data;
    logic                       in_valid;
    logic [2:0]                 decim;
    logic                       clr;
    logic [DATA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [$clog2(DEPTH):0]     level;
    logic                       overflow;

    modport master (
        output in_data, in_valid, decim, clr, out_ready,
        input  out_data, out_valid, level, overflow
    );

    modport slave (
        input  in_data, in_valid, decim, clr, out_ready,
        output out_data, out_valid, level, overflow
    );
endinterface

// File: rtl/fir_decim_fifo.sv
// Decimator that keeps one of every R filter samples and buffers the kept
// samples in a first-word-fall-through FIFO with a sticky overflow flag.
module fir_decim_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic               clk,
    input  logic               rst,
    fir_decim_fifo_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [2:0]        phase_q, phase_d;
    logic [2:0]        rm1_q, rm1_d;      // active ratio minus one
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [LW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;

    logic              keep;
    logic              full;
    logic              push;
    logic              pop;

    logic [DATA_W-1:0] mem [DEPTH];

    always_comb begin
        full    = (count_q == LW'(DEPTH));
        pop     = (count_q != '0) && bus.out_ready && !bus.clr;
        keep    = bus.in_valid && (phase_q == 3'd0) && !bus.clr;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push    = keep && (!full || pop);

        phase_d = phase_q;
        rm1_d   = rm1_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;

        if (bus.clr) begin
            phase_d = 3'd0;
            rm1_d   = bus.decim;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            // The ratio reloads on every keep, so the new period already uses it.
            if (keep) begin
                rm1_d   = bus.decim;
                phase_d = (bus.decim == 3'd0) ? 3'd0 : 3'd1;
            end else if (bus.in_valid) begin
                phase_d = (phase_q == rm1_q) ? 3'd0 : phase_q + 3'd1;
            end

            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + LW'(push) - LW'(pop);

            if (keep && full && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= 3'd0;
            rm1_q   <= 3'd0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rm1_q   <= rm1_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.in_data;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = (count_q != '0) ? mem[rptr_q] : '0;
    assign bus.level     = count_q;
    assign bus.overflow  = ovf_q;
endmodule
